// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  localparam int          BYTES_PER_INSTR = 4;
  localparam logic [31:0] IFU_RESET_PC    = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ERR
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
);

  logic              enable;
  logic [ADDR_W-1:0] memAddr;
  logic              memRdEn;
  logic [7:0]        memRdData;
  logic              redirect;
  logic [31:0]       redirectPc;
  logic              instrValid;
  logic              instrReady;
  logic [31:0]       instrOut;
  logic [31:0]       instrPc;
  logic              fetchErr;

  // fetch unit side
  modport master (
    input  enable, memRdData, redirect, redirectPc, instrReady,
    output memAddr, memRdEn, instrValid, instrOut, instrPc, fetchErr
  );

  // core / memory side
  modport slave (
    output enable, memRdData, redirect, redirectPc, instrReady,
    input  memAddr, memRdEn, instrValid, instrOut, instrPc, fetchErr
  );

endinterface

// File: rtl/ifu_word_assembler.sv
// rtl/ifu_word_assembler.sv - collects four bytes into a big-endian 32-bit word
module ifu_word_assembler
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        beat_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  // The last byte is merged combinationally so the top can register the full word on the same edge.
  assign word_o = {sr_q, byte_i};
  assign done_o = beat_i && !clear_i && (cnt_q == 2'(BYTES_PER_INSTR - 1));

  // Beat counter and shift register; clear drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (beat_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {sr_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and byte-serial instruction fetcher (optional IFU_PREFETCH_EN)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  ifu_state_t        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [1:0]        issue_cnt_q, issue_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic              fetch_err_q, fetch_err_d;
`ifdef IFU_PREFETCH_EN
  logic [31:0]       pfb_word_q, pfb_word_d;
  logic              pfb_full_q, pfb_full_d;
  logic              pf_busy_q, pf_busy_d;
`endif

  logic        asm_clear;
  logic        asm_done;
  logic [31:0] asm_word;
  logic        start;
  logic [31:0] start_addr;
  logic        hs;

  assign bus.memAddr    = mem_addr_q;
  assign bus.memRdEn    = mem_rd_en_q;
  assign bus.instrValid = instr_valid_q;
  assign bus.instrOut   = instr_out_q;
  assign bus.instrPc    = instr_pc_q;
  assign bus.fetchErr   = fetch_err_q;

  assign hs = instr_valid_q && bus.instrReady;

  ifu_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (asm_clear),
    .beat_i  (rd_vld_q),
    .byte_i  (bus.memRdData),
    .word_o  (asm_word),
    .done_o  (asm_done)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC[ADDR_W-1:0];
      mem_rd_en_q   <= 1'b0;
      issue_cnt_q   <= '0;
      rd_vld_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= RESET_PC;
      fetch_err_q   <= 1'b0;
`ifdef IFU_PREFETCH_EN
      pfb_word_q    <= '0;
      pfb_full_q    <= 1'b0;
      pf_busy_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      issue_cnt_q   <= issue_cnt_d;
      rd_vld_q      <= rd_vld_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      fetch_err_q   <= fetch_err_d;
`ifdef IFU_PREFETCH_EN
      pfb_word_q    <= pfb_word_d;
      pfb_full_q    <= pfb_full_d;
      pf_busy_q     <= pf_busy_d;
`endif
    end
  end

  // Next state: read issue, FSM, handshake, then redirect overriding everything outside ERR.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_en_d   = 1'b0;
    issue_cnt_d   = issue_cnt_q;
    rd_vld_d      = mem_rd_en_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    fetch_err_d   = fetch_err_q;
    asm_clear     = 1'b0;
    start         = 1'b0;
    start_addr    = pc_q;
`ifdef IFU_PREFETCH_EN
    pfb_word_d    = pfb_word_q;
    pfb_full_d    = pfb_full_q;
    pf_busy_d     = pf_busy_q;
`endif

    // A started burst keeps issuing until all four addresses are out.
    if (mem_rd_en_q && issue_cnt_q != 2'(BYTES_PER_INSTR - 1)) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = mem_addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d    = FETCH;
          start      = 1'b1;
          start_addr = pc_q;
        end
      end
      FETCH: begin
        if (asm_done) begin
          state_d       = HOLD;
          instr_valid_d = 1'b1;
          instr_out_d   = asm_word;
          instr_pc_d    = pc_q;
        end
      end
      HOLD: begin
`ifdef IFU_PREFETCH_EN
        if (hs) begin
          pc_d = pc_q + 32'(BYTES_PER_INSTR);
          if (pfb_full_q) begin
            instr_out_d = pfb_word_q;
            instr_pc_d  = pc_q + 32'(BYTES_PER_INSTR);
            pfb_full_d  = 1'b0;
          end else if (asm_done) begin
            instr_out_d = asm_word;
            instr_pc_d  = pc_q + 32'(BYTES_PER_INSTR);
            pf_busy_d   = 1'b0;
          end else if (pf_busy_q) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH;
            pf_busy_d     = 1'b0;
          end else begin
            instr_valid_d = 1'b0;
            if (bus.enable) begin
              state_d    = FETCH;
              start      = 1'b1;
              start_addr = pc_q + 32'(BYTES_PER_INSTR);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (asm_done) begin
          pfb_word_d = asm_word;
          pfb_full_d = 1'b1;
          pf_busy_d  = 1'b0;
        end else if (!pfb_full_q && !pf_busy_q && bus.enable) begin
          start      = 1'b1;
          start_addr = pc_q + 32'(BYTES_PER_INSTR);
          pf_busy_d  = 1'b1;
        end
`else
        if (hs) begin
          pc_d          = pc_q + 32'(BYTES_PER_INSTR);
          instr_valid_d = 1'b0;
          if (bus.enable) begin
            state_d    = FETCH;
            start      = 1'b1;
            start_addr = pc_q + 32'(BYTES_PER_INSTR);
          end else begin
            state_d = IDLE;
          end
        end
`endif
      end
      default: begin
        mem_rd_en_d = 1'b0;
      end
    endcase

    if (bus.redirect && state_q != ERR) begin
      instr_valid_d = 1'b0;
      asm_clear     = 1'b1;
      rd_vld_d      = 1'b0;
      mem_rd_en_d   = 1'b0;
      start         = 1'b0;
`ifdef IFU_PREFETCH_EN
      pfb_full_d    = 1'b0;
      pf_busy_d     = 1'b0;
`endif
      if (bus.redirectPc[1:0] != 2'b00) begin
        state_d     = ERR;
        fetch_err_d = 1'b1;
      end else begin
        state_d    = FETCH;
        pc_d       = bus.redirectPc;
        start      = 1'b1;
        start_addr = bus.redirectPc;
      end
    end

    if (start) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = start_addr[ADDR_W-1:0];
      issue_cnt_d = '0;
    end
  end

endmodule
